rv_lsu: RTL

- Load/store unit: the initiator side of the data-memory port. Sits in the MEM stage between the pipeline and the byte-addressed data memory.
- Decodes the RV32I load/store funct3 into the memory byte-control code and drives address, write data and write enable.
- Aligned accesses are passed through in one cycle.
- Misaligned accesses are split into sequential single-byte accesses, with the pipeline stalled until the last byte completes; load data is assembled and sign/zero-extended.

---
 rtl/rv_lsu_if.sv | 44 ++++
 rtl/rv_lsu.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/rv_lsu_if.sv
`default_nettype none
// ============================================================================
// Module  : rv_lsu_if
// Brief   : Data-memory port between the load/store unit (master) and the
//           byte-addressed data memory (slave).
// Rev     : 1.0  initial release
// ============================================================================

`ifndef DMEM_A_BIT
`define DMEM_A_BIT 16
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_BYTECTRL_BYTE
`define DMEM_BYTECTRL_BYTE  3'b000
`define DMEM_BYTECTRL_HALF  3'b001
`define DMEM_BYTECTRL_WORD  3'b010
`define DMEM_BYTECTRL_BYTEU 3'b100
`define DMEM_BYTECTRL_HALFU 3'b101
`endif

interface rv_lsu_if #(
  parameter int A_BIT = `DMEM_A_BIT,
  parameter int XW    = `XLEN
);
  logic [A_BIT-1:0] dmem_a;
  logic [XW-1:0]    dmem_wd;
  logic             dmem_we;
  logic [2:0]       dmem_bytectrl;
  logic [XW-1:0]    dmem_rd;

  modport master (
    output dmem_a, dmem_wd, dmem_we, dmem_bytectrl,
    input  dmem_rd
  );

  modport slave (
    input  dmem_a, dmem_wd, dmem_we, dmem_bytectrl,
    output dmem_rd
  );
endinterface

`default_nettype wire

// File: rtl/rv_lsu.sv
`default_nettype none
// ============================================================================
// Module  : rv_lsu
// Brief   : MEM-stage load/store unit; passes aligned accesses through and
//           splits misaligned ones into byte accesses. Optional build macro
//           RV_LSU_MISALIGN_TRAP_EN traps misaligned accesses instead.
// Rev     : 1.0  initial release
// ============================================================================

`ifndef DMEM_A_BIT
`define DMEM_A_BIT 16
`endif
`ifndef XLEN
`define XLEN 32
`endif
`ifndef DMEM_BYTECTRL_BYTE
`define DMEM_BYTECTRL_BYTE  3'b000
`define DMEM_BYTECTRL_HALF  3'b001
`define DMEM_BYTECTRL_WORD  3'b010
`define DMEM_BYTECTRL_BYTEU 3'b100
`define DMEM_BYTECTRL_HALFU 3'b101
`endif

module rv_lsu #(
  parameter int A_BIT = `DMEM_A_BIT,
  parameter int XW    = `XLEN
) (
  input  wire logic             i_lsu_clk,
  input  wire logic             i_lsu_rstn,
  input  wire logic             i_lsu_valid,
  input  wire logic             i_lsu_we,
  input  wire logic [2:0]       i_lsu_funct3,
  input  wire logic [A_BIT-1:0] i_lsu_addr,
  input  wire logic [XW-1:0]    i_lsu_wdata,
  output logic      [XW-1:0]    o_lsu_rdata,
  output logic                  o_lsu_done,
  output logic                  o_lsu_stall,
  output logic                  o_lsu_misalign,
  rv_lsu_if.master              dmem
);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_SPLIT = 1'b1
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [1:0]       r_cnt, w_cnt_nxt;
  logic [23:0]      r_acc, w_acc_nxt;

  logic             w_legal, w_is_half, w_is_word, w_misalign;
  logic [2:0]       w_size_bc;
  logic [1:0]       w_last;
  logic [7:0]       w_wbyte;
  logic [15:0]      w_half;

  logic [A_BIT-1:0] w_a;
  logic [XW-1:0]    w_wd, w_rdata;
  logic             w_we, w_done, w_trap;
  logic [2:0]       w_bc;

  // Size decode; unsigned variants are meaningless for stores and are rejected.
  always_comb begin
    w_legal   = 1'b1;
    w_is_half = 1'b0;
    w_is_word = 1'b0;
    w_size_bc = `DMEM_BYTECTRL_BYTE;
    case (i_lsu_funct3)
      3'b000: w_size_bc = `DMEM_BYTECTRL_BYTE;
      3'b100: begin w_size_bc = `DMEM_BYTECTRL_BYTEU; w_legal = ~i_lsu_we; end
      3'b001: begin w_size_bc = `DMEM_BYTECTRL_HALF;  w_is_half = 1'b1; end
      3'b101: begin w_size_bc = `DMEM_BYTECTRL_HALFU; w_is_half = 1'b1; w_legal = ~i_lsu_we; end
      3'b010: begin w_size_bc = `DMEM_BYTECTRL_WORD;  w_is_word = 1'b1; end
      default: w_legal = 1'b0;
    endcase
  end

  assign w_misalign = w_legal & ((w_is_half & i_lsu_addr[0]) |
                                 (w_is_word & (|i_lsu_addr[1:0])));
  assign w_last     = w_is_half ? 2'd1 : 2'd3;
  assign w_wbyte    = i_lsu_wdata[{r_cnt, 3'b000} +: 8];
  assign w_half     = {dmem.dmem_rd[7:0], r_acc[7:0]};

  always_comb begin
    w_a         = i_lsu_addr;
    w_wd        = i_lsu_wdata;
    w_we        = 1'b0;
    w_bc        = w_size_bc;
    w_done      = 1'b0;
    w_rdata     = '0;
    w_trap      = 1'b0;
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    case (r_state)
      ST_IDLE: begin
        if (i_lsu_valid) begin
          if (!w_legal) begin
            w_done = 1'b1;
          end else if (w_misalign) begin
`ifdef RV_LSU_MISALIGN_TRAP_EN
            w_trap = 1'b1;
            w_done = 1'b1;
`else
            w_bc        = `DMEM_BYTECTRL_BYTEU;
            w_wd        = {{(XW-8){1'b0}}, i_lsu_wdata[7:0]};
            w_we        = i_lsu_we;
            w_acc_nxt   = {16'd0, dmem.dmem_rd[7:0]};
            w_cnt_nxt   = 2'd1;
            w_state_nxt = ST_SPLIT;
`endif
          end else begin
            w_we    = i_lsu_we;
            w_done  = 1'b1;
            w_rdata = dmem.dmem_rd;
          end
        end
      end
      ST_SPLIT: begin
        if (!i_lsu_valid) begin
          // Abort: bytes already stored are not rolled back.
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = 2'd0;
          w_acc_nxt   = 24'd0;
        end else begin
          w_a  = i_lsu_addr + A_BIT'(r_cnt);
          w_bc = `DMEM_BYTECTRL_BYTEU;
          w_wd = {{(XW-8){1'b0}}, w_wbyte};
          w_we = i_lsu_we;
          if (r_cnt == w_last) begin
            w_done = 1'b1;
            if (w_is_half)
              w_rdata = {{(XW-16){~i_lsu_funct3[2] & w_half[15]}}, w_half};
            else
              w_rdata = XW'({dmem.dmem_rd[7:0], r_acc});
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 2'd0;
            w_acc_nxt   = 24'd0;
          end else begin
            case (r_cnt)
              2'd1:    w_acc_nxt[15:8]  = dmem.dmem_rd[7:0];
              2'd2:    w_acc_nxt[23:16] = dmem.dmem_rd[7:0];
              default: w_acc_nxt[7:0]   = dmem.dmem_rd[7:0];
            endcase
            w_cnt_nxt = r_cnt + 2'd1;
          end
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_lsu_clk or negedge i_lsu_rstn) begin
    if (!i_lsu_rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= 2'd0;
      r_acc   <= 24'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

  // Reset masks every output so no write can slip out while rstn is low.
  assign dmem.dmem_a        = i_lsu_rstn ? w_a  : '0;
  assign dmem.dmem_wd       = i_lsu_rstn ? w_wd : '0;
  assign dmem.dmem_we       = i_lsu_rstn & w_we;
  assign dmem.dmem_bytectrl = i_lsu_rstn ? w_bc : 3'b000;
  assign o_lsu_rdata        = i_lsu_rstn ? w_rdata : '0;
  assign o_lsu_done         = i_lsu_rstn & w_done;
  assign o_lsu_stall        = i_lsu_rstn & i_lsu_valid & ~w_done;
  assign o_lsu_misalign     = i_lsu_rstn & w_trap;

endmodule

`default_nettype wire
